// File: rtl/snn_spike_bridge.sv
// snn_spike_bridge: collects one frame of layer results as clamped spike
// times, then replays the frame as an addressed valid/ack spike stream.
module snn_spike_bridge #(
    parameter int                       N_NEURONS = 32,
    parameter int                       ACC_W     = 32,
    parameter int                       TIME_W    = 32,
    parameter int                       SHIFT     = 0,
    parameter logic signed [TIME_W-1:0] T_MIN     = 32'h00010000,
    parameter logic signed [TIME_W-1:0] T_MAX     = 32'h7FFFFFFF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clk_enable,
    input  logic                         i_result_valid,
    input  logic signed [ACC_W-1:0]      i_result_data,
    input  logic                         i_last_result,
    output logic                         o_result_ack,
    output logic                         o_spike_valid,
    output logic signed [TIME_W-1:0]     o_spike_time,
    output logic [$clog2(N_NEURONS)-1:0] o_spike_addr,
    output logic                         o_last_spike,
    input  logic                         i_spike_ack,
    output logic                         o_frame_done,
    output logic                         o_frame_error
);

    localparam int ADDR_W = $clog2(N_NEURONS);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int CMP_W  = ((ACC_W > TIME_W) ? ACC_W : TIME_W) + 1;

    typedef enum logic [1:0] {
        S_COLLECT,
        S_READ,
        S_EMIT,
        S_DONE
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    wr_cnt_q;
    logic [CNT_W-1:0]    frame_len_q;
    logic [ADDR_W-1:0]   rd_idx_q;
    logic [TIME_W-1:0]   mem_q [N_NEURONS];
    logic [TIME_W-1:0]   time_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                valid_q;
    logic                last_q;
    logic                done_q;
    logic                err_q;

    logic                xfer;
    logic                wr_full;
    logic                rd_last;
    logic signed [ACC_W-1:0] shifted;
    logic signed [CMP_W-1:0] s_ext;
    logic signed [CMP_W-1:0] min_ext;
    logic signed [CMP_W-1:0] max_ext;
    logic [TIME_W-1:0]   conv_time;

    assign o_result_ack  = (state_q == S_COLLECT) & i_clk_enable;
    assign o_spike_valid = valid_q;
    assign o_spike_time  = time_q;
    assign o_spike_addr  = addr_q;
    assign o_last_spike  = last_q;
    assign o_frame_done  = done_q;
    assign o_frame_error = err_q;

    assign xfer    = i_result_valid & o_result_ack;
    assign wr_full = (wr_cnt_q + CNT_W'(1)) == CNT_W'(N_NEURONS);
    assign rd_last = ({1'b0, rd_idx_q} == (frame_len_q - CNT_W'(1)));

    // Compare one bit wider than either operand so extreme values never wrap.
    assign shifted = i_result_data >>> SHIFT;
    assign s_ext   = {{(CMP_W-ACC_W){shifted[ACC_W-1]}}, shifted};
    assign min_ext = {{(CMP_W-TIME_W){T_MIN[TIME_W-1]}}, T_MIN};
    assign max_ext = {{(CMP_W-TIME_W){T_MAX[TIME_W-1]}}, T_MAX};

    always_comb begin
        conv_time = s_ext[TIME_W-1:0];
        if (s_ext < min_ext) begin
            conv_time = T_MIN;
        end else if (s_ext > max_ext) begin
            conv_time = T_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            mem_q[wr_cnt_q[ADDR_W-1:0]] <= conv_time;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_COLLECT;
            wr_cnt_q    <= '0;
            frame_len_q <= '0;
            rd_idx_q    <= '0;
            time_q      <= '0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else if (i_clk_enable) begin
            unique case (state_q)
                S_COLLECT: begin
                    if (xfer) begin
                        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
                        if (i_last_result || wr_full) begin
                            state_q     <= S_READ;
                            rd_idx_q    <= '0;
                            frame_len_q <= wr_cnt_q + CNT_W'(1);
                            if (!i_last_result) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                S_READ: begin
                    time_q  <= mem_q[rd_idx_q];
                    addr_q  <= rd_idx_q;
                    last_q  <= rd_last;
                    valid_q <= 1'b1;
                    state_q <= S_EMIT;
                end
                S_EMIT: begin
                    if (i_spike_ack) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (last_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            rd_idx_q <= rd_idx_q + ADDR_W'(1);
                            state_q  <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    done_q   <= 1'b0;
                    wr_cnt_q <= '0;
                    state_q  <= S_COLLECT;
                end
                default: state_q <= S_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_spike_bridge.sv
// Self-checking bench for snn_spike_bridge: clamp table, directed frame
// sequences and random frames checked against a frame-level model.
module tb_snn_spike_bridge;

    localparam int          N    = 32;
    localparam int          AW   = 40;
    localparam int          TW   = 32;
    localparam int          SH   = 0;
    localparam logic [31:0] TMIN = 32'h00010000;
    localparam logic [31:0] TMAX = 32'h7FFFFFFF;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          en     = 1'b1;
    logic          rvalid = 1'b0;
    logic          rlast  = 1'b0;
    logic          sack   = 1'b1;
    logic [AW-1:0] rdata  = '0;
    logic          rack;
    logic          svalid;
    logic [TW-1:0] stime;
    logic [4:0]    saddr;
    logic          slast;
    logic          fdone;
    logic          ferr;

    snn_spike_bridge #(
        .N_NEURONS(N), .ACC_W(AW), .TIME_W(TW), .SHIFT(SH),
        .T_MIN(TMIN), .T_MAX(TMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_clk_enable(en),
        .i_result_valid(rvalid), .i_result_data(rdata),
        .i_last_result(rlast), .o_result_ack(rack),
        .o_spike_valid(svalid), .o_spike_time(stime),
        .o_spike_addr(saddr), .o_last_spike(slast),
        .i_spike_ack(sack), .o_frame_done(fdone),
        .o_frame_error(ferr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] t;
        logic [4:0]  a;
        logic        l;
    } spike_t;

    typedef struct {
        logic [AW-1:0] v;
        logic [31:0]   t;
    } vec_t;

    int     errors = 0;
    int     checks = 0;
    int     done_cnt = 0;
    int     en_mode = 0;
    int     ack_mode = 0;
    int     en_cnt = 0;
    spike_t got_q[$];
    spike_t exp_q[$];
    logic [31:0] mdl_vals[$];
    logic   mdl_err = 1'b0;
    spike_t pend;
    bit     pend_v = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] conv(input logic [AW-1:0] v);
        longint s;
        logic [31:0] r;
        s = longint'($signed(v)) >>> SH;
        if (s < longint'(TMIN)) r = TMIN;
        else if (s > longint'(TMAX)) r = TMAX;
        else r = 32'(s);
        return r;
    endfunction

    // Frame-level model: gather results, release a whole frame at its end.
    task automatic model_push(input logic [AW-1:0] v, input logic last);
        spike_t sp;
        mdl_vals.push_back(conv(v));
        if (last || mdl_vals.size() == N) begin
            if (!last) mdl_err = 1'b1;
            for (int i = 0; i < mdl_vals.size(); i++) begin
                sp.t = mdl_vals[i];
                sp.a = 5'(i);
                sp.l = (i == mdl_vals.size() - 1);
                exp_q.push_back(sp);
            end
            mdl_vals.delete();
        end
    endtask

    function automatic logic [AW-1:0] rand_val();
        logic [63:0] w;
        w = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: return AW'($urandom_range(0, 32'h3FFFF));
            1: return w[AW-1:0];
            2: return AW'($urandom);
            default: return AW'($urandom_range(32'h10000, 32'h7FFFFFFF));
        endcase
    endfunction

    always @(negedge clk) begin
        if (en_mode == 1) begin
            en_cnt++;
            if (en_cnt == 3) begin
                en_cnt = 0;
                en = ~en;
            end
        end else begin
            en = (en_mode == 0);
        end
        sack = (ack_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
    end

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            pend_v = 0;
        end else begin
            if (pend_v) begin
                check("hold_valid", svalid, 1);
                check("hold_time", stime, pend.t);
                check("hold_addr", saddr, pend.a);
            end
            pend_v = 0;
            if (svalid && sack && en) begin
                got_q.push_back({stime, saddr, slast});
            end else if (svalid) begin
                pend_v = 1;
                pend = {stime, saddr, slast};
            end
            if (fdone && en) done_cnt++;
        end
    end

    task automatic push(input logic [AW-1:0] v, input logic last);
        int guard;
        guard = 0;
        @(negedge clk);
        rvalid = 1'b1;
        rdata  = v;
        rlast  = last;
        #1;
        while (!rack && guard < 3000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("push_ack", rack, 1);
        if (rack) model_push(v, last);
    endtask

    task automatic idle();
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int guard;
        guard = 0;
        while (done_cnt < target && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("frame_done_seen", done_cnt >= target, 1);
        repeat (4) @(negedge clk);
        check("frame_done_once", done_cnt, target);
    endtask

    task automatic compare(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_time"}, got_q[i].t, exp_q[i].t);
            check({tag, "_addr"}, got_q[i].a, exp_q[i].a);
            check({tag, "_last"}, got_q[i].l, exp_q[i].l);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic nominal_frame(input string tag);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < N; i++) push(AW'(i * 32'h20000), i == N - 1);
        idle();
        wait_done(d0 + 1);
        compare(tag);
        check({tag, "_err"}, ferr, mdl_err);
    endtask

    initial begin
        vec_t tbl[8];
        int   d0;
        int   len;
        int   guard;
        logic prev_done;

        tbl[0] = '{40'hFF_FFFF_FFFB, 32'h00010000};
        tbl[1] = '{40'h00_0000_FFFF, 32'h00010000};
        tbl[2] = '{40'h00_7FFF_FFFF, 32'h7FFFFFFF};
        tbl[3] = '{40'h10_0000_0000, 32'h7FFFFFFF};
        tbl[4] = '{40'h00_0001_0000, 32'h00010000};
        tbl[5] = '{40'h00_1234_5678, 32'h12345678};
        tbl[6] = '{40'h80_0000_0000, 32'h00010000};
        tbl[7] = '{40'h00_FFFF_FFFF, 32'h7FFFFFFF};

        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", svalid, 0);
        check("rst_time", stime, 0);
        check("rst_addr", saddr, 0);
        check("rst_last", slast, 0);
        check("rst_done", fdone, 0);
        check("rst_err", ferr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ack_after_reset", rack, 1);
        en_mode = 2;
        @(negedge clk);
        #1;
        check("ack_gated_by_enable", rack, 0);
        en_mode = 0;
        @(negedge clk);

        nominal_frame("nominal");

        d0 = done_cnt;
        for (int i = 0; i < 8; i++) push(tbl[i].v, i == 7);
        idle();
        wait_done(d0 + 1);
        check("clamp_count", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            check("clamp_time", got_q[i].t, tbl[i].t);
            check("clamp_addr", got_q[i].a, 5'(i));
        end
        got_q.delete();
        exp_q.delete();

        d0 = done_cnt;
        for (int i = 0; i < 10; i++) push(rand_val(), i == 9);
        idle();
        wait_done(d0 + 1);
        check("early_count", got_q.size(), 10);
        compare("early");
        check("early_err", ferr, 0);
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) push(rand_val(), i == 4);
        idle();
        wait_done(d0 + 1);
        compare("after_early");

        ack_mode = 1;
        for (int f = 0; f < 4; f++) begin
            d0 = done_cnt;
            len = $urandom_range(1, N);
            for (int i = 0; i < len; i++) push(rand_val(), i == len - 1);
            idle();
            wait_done(d0 + 1);
            compare("random");
            check("random_err", ferr, mdl_err);
        end

        d0 = done_cnt;
        for (int i = 0; i < 20; i++) push(rand_val(), i == 19);
        @(negedge clk);
        rvalid = 1'b1;
        rdata  = rand_val();
        rlast  = 1'b0;
        #1;
        prev_done = 1'b0;
        guard = 0;
        while (!rack && guard < 3000) begin
            prev_done = fdone;
            @(negedge clk);
            #1;
            guard++;
        end
        check("bp_ack_after_done", prev_done, 1);
        check("bp_ack_rises", rack, 1);
        model_push(rdata, 1'b0);
        for (int i = 1; i < 12; i++) push(rand_val(), i == 11);
        idle();
        wait_done(d0 + 2);
        compare("backpressure");
        ack_mode = 0;

        en_mode = 1;
        nominal_frame("enable_toggle");
        en_mode = 0;
        @(negedge clk);

        d0 = done_cnt;
        for (int i = 0; i < N - 1; i++) push(rand_val(), 1'b0);
        check("err_before_full", ferr, 0);
        push(rand_val(), 1'b0);
        idle();
        #1;
        check("err_after_full", ferr, 1);
        wait_done(d0 + 1);
        compare("missing_last");
        ack_mode = 1;
        nominal_frame("err_sticky");
        check("err_still_set", ferr, 1);
        ack_mode = 0;

        for (int i = 0; i < N; i++) push(AW'(i * 32'h20000), i == N - 1);
        idle();
        guard = 0;
        #1;
        while (!(svalid && saddr == 5'd12) && guard < 3000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("reached_addr12", svalid && saddr == 5'd12, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", svalid, 0);
        check("midrst_time", stime, 0);
        check("midrst_addr", saddr, 0);
        check("midrst_last", slast, 0);
        check("midrst_done", fdone, 0);
        check("midrst_err", ferr, 0);
        got_q.delete();
        exp_q.delete();
        mdl_vals.delete();
        mdl_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nominal_frame("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
